// File: rtl/timer_apb_slave.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp + prescaler) on an APB-like bus.
// The bus response is delayed by a fixed, parameterised number of wait states.
module timer_apb_slave #(
  parameter int unsigned WaitStates = 0,
  parameter logic [31:0] CmpResetHi = 32'hFFFF_FFFF,
  parameter logic [31:0] CmpResetLo = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        select,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irqTimer
);

  localparam int unsigned WaitLoadInt = (WaitStates > 0) ? WaitStates - 1 : 0;
  localparam logic [3:0]  WaitLoad    = WaitLoadInt[3:0];

  localparam logic [2:0] RegMtimeLo = 3'd0;
  localparam logic [2:0] RegMtimeHi = 3'd1;
  localparam logic [2:0] RegCmpLo   = 3'd2;
  localparam logic [2:0] RegCmpHi   = 3'd3;
  localparam logic [2:0] RegCtrl    = 3'd4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  div_q, div_d;
  logic        en_q, en_d;
  logic        irq_q, irq_d;

  logic [2:0]  reg_sel;
  logic        bus_we;
  logic        bus_re;
  logic        unused_addr;

  assign reg_sel     = addr[4:2];
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign ready    = (state_q == StResp);
  assign bus_we   = ready & write;
  assign bus_re   = ready & ~write;
  assign irqTimer = irq_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (select && enable) begin
          if (WaitStates == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            wcnt_d  = WaitLoad;
          end
        end
      end
      StWait: begin
        // Master backed off mid-transfer: abandon it without committing.
        if (!(select && enable)) begin
          state_d = StIdle;
        end else if (wcnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    pcnt_d   = pcnt_q;
    div_d    = div_q;
    en_d     = en_q;
    irq_d    = en_q & (mtime_q >= cmp_q);

    if (en_q) begin
      if (pcnt_q == div_q) begin
        pcnt_d  = 8'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end

    // Bus writes override the same-cycle increment.
    if (bus_we) begin
      case (reg_sel)
        RegMtimeLo: mtime_d = {mtime_q[63:32], wdata};
        RegMtimeHi: mtime_d = {wdata, mtime_q[31:0]};
        RegCmpLo:   cmp_d   = {cmp_q[63:32], wdata};
        RegCmpHi:   cmp_d   = {wdata, cmp_q[31:0]};
        RegCtrl: begin
          en_d   = wdata[0];
          div_d  = wdata[15:8];
          pcnt_d = 8'd0;
        end
        default: ;
      endcase
    end

    // Latch the high word so a LO-then-HI read pair is coherent across a carry.
    if (bus_re && (reg_sel == RegMtimeLo)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (ready) begin
      case (reg_sel)
        RegMtimeLo: rdata = mtime_q[31:0];
        RegMtimeHi: rdata = shadow_q;
        RegCmpLo:   rdata = cmp_q[31:0];
        RegCmpHi:   rdata = cmp_q[63:32];
        RegCtrl:    rdata = {16'd0, div_q, 7'd0, en_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wcnt_q   <= 4'd0;
      mtime_q  <= 64'd0;
      cmp_q    <= {CmpResetHi, CmpResetLo};
      shadow_q <= 32'd0;
      pcnt_q   <= 8'd0;
      div_q    <= 8'd0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      pcnt_q   <= pcnt_d;
      div_q    <= div_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_apb_slave.sv
// Bench for timer_apb_slave: two instances (0 and 3 wait states) checked every cycle
// against a transaction-level timer model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_timer_apb_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        enable;
  logic        write;
  logic [1:0]  sel;
  logic [1:0]  rdy;
  logic [1:0]  irqv;
  logic [31:0] rd0, rd1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timer_apb_slave #(
    .WaitStates(0),
    .CmpResetHi(32'hFFFF_FFFF),
    .CmpResetLo(32'hFFFF_FFFF)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .select  (sel[0]),
    .enable  (enable),
    .write   (write),
    .wdata   (wdata),
    .rdata   (rd0),
    .ready   (rdy[0]),
    .irqTimer(irqv[0])
  );

  timer_apb_slave #(
    .WaitStates(3),
    .CmpResetHi(32'h0000_0000),
    .CmpResetLo(32'h0000_0040)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .select  (sel[1]),
    .enable  (enable),
    .write   (write),
    .wdata   (wdata),
    .rdata   (rd1),
    .ready   (rdy[1]),
    .irqTimer(irqv[1])
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  logic [31:0] m_shadow[2];
  logic [7:0]  m_pcnt[2];
  logic [7:0]  m_div[2];
  bit          m_en[2];
  bit          m_resp[2];
  bit          m_irq[2];
  int          m_age[2];

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic model_reset(input int i);
    m_mtime[i]  = 64'd0;
    m_cmp[i]    = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_0040;
    m_shadow[i] = 32'd0;
    m_pcnt[i]   = 8'd0;
    m_div[i]    = 8'd0;
    m_en[i]     = 1'b0;
    m_resp[i]   = 1'b0;
    m_irq[i]    = 1'b0;
    m_age[i]    = 0;
  endtask

  task automatic model_step(input int i);
    logic [63:0] old_t;
    bit          irq_n;
    old_t = m_mtime[i];
    irq_n = m_en[i] && (old_t >= m_cmp[i]);
    if (m_en[i]) begin
      if (m_pcnt[i] == m_div[i]) begin
        m_pcnt[i]  = 8'd0;
        m_mtime[i] = old_t + 64'd1;
      end else begin
        m_pcnt[i] = m_pcnt[i] + 8'd1;
      end
    end
    if (m_resp[i]) begin
      m_resp[i] = 1'b0;
      if (write) begin
        case (addr[4:2])
          3'd0: m_mtime[i] = {old_t[63:32], wdata};
          3'd1: m_mtime[i] = {wdata, old_t[31:0]};
          3'd2: m_cmp[i][31:0]  = wdata;
          3'd3: m_cmp[i][63:32] = wdata;
          3'd4: begin
            m_en[i]   = wdata[0];
            m_div[i]  = wdata[15:8];
            m_pcnt[i] = 8'd0;
          end
          default: ;
        endcase
      end else if (addr[4:2] == 3'd0) begin
        m_shadow[i] = old_t[63:32];
      end
    end else if (sel[i] && enable) begin
      // Transfer completes once select&enable have been seen on WaitStates+1 edges.
      m_age[i] = m_age[i] + 1;
      if (m_age[i] == ws_of(i) + 1) begin
        m_resp[i] = 1'b1;
        m_age[i]  = 0;
      end
    end else begin
      m_age[i] = 0;
    end
    m_irq[i] = irq_n;
  endtask

  function automatic logic [31:0] exp_rdata(input int i);
    if (!m_resp[i]) return 32'd0;
    case (addr[4:2])
      3'd0:    return m_mtime[i][31:0];
      3'd1:    return m_shadow[i];
      3'd2:    return m_cmp[i][31:0];
      3'd3:    return m_cmp[i][63:32];
      3'd4:    return {16'd0, m_div[i], 7'd0, m_en[i]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) model_reset(i);
      else model_step(i);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("ready", i, 32'(rdy[i]), 32'(m_resp[i]));
      chk("rdata", i, (i == 0) ? rd0 : rd1, exp_rdata(i));
      chk("irq", i, 32'(irqv[i]), 32'(m_irq[i]));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the falling edge after the completing edge.
  task automatic xfer(input int i, input bit wr_en, input logic [2:0] r,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    addr   = {27'h02A_AAAA, r, 2'b01};
    write  = wr_en;
    wdata  = d;
    sel[i] = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    lat = 0;
    rd  = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy[i]) begin
        lat = k;
        rd  = (i == 0) ? rd0 : rd1;
        break;
      end
    end
    if (lat == 0) chk("xfer_timeout", i, 32'd0, 32'd1);
    @(negedge clk);
    sel    = 2'b00;
    enable = 1'b0;
    write  = 1'b0;
  endtask

  task automatic wr(input int i, input logic [2:0] r, input logic [31:0] d);
    logic [31:0] rd;
    int          lat;
    xfer(i, 1'b1, r, d, rd, lat);
  endtask

  task automatic rd_expect(input string name, input int i, input logic [2:0] r,
                           input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    xfer(i, 1'b0, r, 32'd0, rd, lat);
    chk(name, i, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    rst = 1'b0; sel = 2'b00; enable = 1'b0; write = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("rst_rdata", 0, rd0, 32'd0);
    chk("rst_irq", 0, 32'(irqv[0]), 32'd0);
    rd_expect("rst_cmp_lo", 0, 3'd2, 32'hFFFF_FFFF);
    rd_expect("rst_ctrl", 0, 3'd4, 32'd0);
    rd_expect("rst_cmp_lo", 1, 3'd2, 32'h0000_0040);
    rd_expect("rst_cmp_hi", 1, 3'd3, 32'd0);

    // Zero wait states; free-running at div=0
    xfer(0, 1'b1, 3'd4, 32'h0000_0001, rd, lat);
    chk("lat_ws0", 0, 32'(lat), 32'd1);
    rd_expect("run_lo_a", 0, 3'd0, 32'd2);
    rd_expect("run_lo_b", 0, 3'd0, 32'd5);
    rd_expect("run_lo_c", 0, 3'd0, 32'd8);

    // Prescaler div=3, then restart mid-count
    wr(0, 3'd4, 32'd0);
    wr(0, 3'd0, 32'd0);
    wr(0, 3'd1, 32'd0);
    wr(0, 3'd4, 32'h0000_0301);
    rd_expect("pre_a", 0, 3'd0, 32'd0);
    rd_expect("pre_b", 0, 3'd0, 32'd1);
    rd_expect("pre_c", 0, 3'd0, 32'd2);
    rd_expect("pre_d", 0, 3'd0, 32'd2);
    rd_expect("pre_e", 0, 3'd0, 32'd3);
    wr(0, 3'd4, 32'h0000_0301);
    rd_expect("restart_a", 0, 3'd0, 32'd4);
    rd_expect("restart_b", 0, 3'd0, 32'd5);
    rd_expect("restart_c", 0, 3'd0, 32'd6);
    rd_expect("restart_d", 0, 3'd0, 32'd6);

    // 64-bit wrap and shadowed high word
    wr(0, 3'd4, 32'd0);
    wr(0, 3'd1, 32'hFFFF_FFFF);
    wr(0, 3'd0, 32'hFFFF_FFFC);
    wr(0, 3'd4, 32'h0000_0001);
    rd_expect("wrap_lo1", 0, 3'd0, 32'hFFFF_FFFE);
    rd_expect("wrap_hi1", 0, 3'd1, 32'hFFFF_FFFF);
    rd_expect("wrap_lo2", 0, 3'd0, 32'd4);
    rd_expect("wrap_hi2", 0, 3'd1, 32'd0);

    // Interrupt assert and clear via compare write
    wr(0, 3'd4, 32'd0);
    wr(0, 3'd3, 32'd0);
    wr(0, 3'd2, 32'h10);
    wr(0, 3'd1, 32'd0);
    wr(0, 3'd0, 32'h0E);
    wr(0, 3'd4, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    chk("irq_before", 0, 32'(irqv[0]), 32'd0);
    @(negedge clk);
    chk("irq_set", 0, 32'(irqv[0]), 32'd1);
    wr(0, 3'd2, 32'h100);
    chk("irq_hold", 0, 32'(irqv[0]), 32'd1);
    @(negedge clk);
    chk("irq_clear", 0, 32'(irqv[0]), 32'd0);

    // Three wait states
    xfer(1, 1'b1, 3'd2, 32'h55, rd, lat);
    chk("lat_ws3", 1, 32'(lat), 32'd4);
    rd_expect("ws3_cmp", 1, 3'd2, 32'h55);

    // Abort during WAIT: no ready, no commit
    addr = {27'd0, 3'd2, 2'b00}; write = 1'b1; wdata = 32'hAA;
    sel[1] = 1'b1; enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_ready", 1, 32'(rdy[1]), 32'd0);
    sel = 2'b00; enable = 1'b0; write = 1'b0;
    repeat (6) @(negedge clk);
    rd_expect("abort_nocommit", 1, 3'd2, 32'h55);

    // Reset asserted during WAIT
    addr = {27'd0, 3'd2, 2'b00}; write = 1'b0;
    sel[1] = 1'b1; enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    sel = 2'b00; enable = 1'b0;
    #1;
    chk("rst_wait_ready", 1, 32'(rdy[1]), 32'd0);
    chk("rst_wait_rdata", 1, rd1, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rd_expect("rst2_cmp_lo", 1, 3'd2, 32'h0000_0040);
    rd_expect("rst2_ctrl", 0, 3'd4, 32'd0);
    rd_expect("rst2_mtime", 0, 3'd0, 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
